multi_wave_gen: RTL and testbench
=================================

# multi_wave_gen

Parametrised multi-mode audio waveform generator built on a phase accumulator. It produces one offset-binary DAC code per `next_sample` strobe, in one of four modes: square, sawtooth, triangle, or LFSR noise. Frequency is set by a frequency-control word, and amplitude by a right-shift volume. It sits between the sample-rate strobe source and the sigma-delta DAC, and is the successor to the fixed-frequency square-wave generator.

## Interface
- `CODE_WIDTH`, 10: width W of the output DAC code.
- `PHASE_WIDTH`, 24: width P of the phase accumulator; must satisfy P ≥ W+1.
- `clk` in 1: system clock, 125 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `next_sample` in 1: single-cycle strobe requesting the next sample.
- `fcw` in P: frequency-control word, i.e. phase increment per sample.
- `mode` in 2: waveform select. 0 = square, 1 = sawtooth, 2 = triangle, 3 = noise.
- `vol` in 3: attenuation, applied as an arithmetic right shift of 0..7 bits.
- `phase_sync` in 1: synchronous phase clear.
- `code` out W: registered offset-binary sample.
- `code_valid` out 1: one-cycle pulse on the cycle after `code` updates.

## Operation
- State registers: `phase[P-1:0]`, `code`, `code_valid`, and `lfsr[15:0]` (noise build only).
- On each posedge with `next_sample`=1:
  - `code` ← f(`phase`, `mode`, `vol`), using the pre-increment phase.
  - `phase` ← `phase` + `fcw`, mod 2^P.
  - `fcw`, `mode` and `vol` are sampled on this edge only. Changes between strobes never alter `code`.
- Signed wave value s, W bits, with top = `phase[P-1 -: W]`:
  - square: s = `phase[P-1]` ? −2^(W−1) : 2^(W−1)−1.
  - sawtooth: s = top − 2^(W−1).
  - triangle: t = `phase[P-1]` ? ~`phase[P-2 -: W]` : `phase[P-2 -: W]`, then s = t − 2^(W−1).
  - noise: s = {`lfsr`[15:16−W]} reinterpreted as signed. When W > 16, the value is zero-extended on the LSB side.
- Output: `code` = (s >>> `vol`) + 2^(W−1), computed in W bits with no overflow possible.
- `phase_sync`=1 without `next_sample`: `phase` ← 0; `code` is unchanged.
- `phase_sync`=1 together with `next_sample`: `code` is computed from phase 0, then `phase` ← `fcw`.
- `fcw`=0: output is constant (DC); this is legal.
- `fcw` ≥ 2^(P−1): aliasing is legal and is not guarded.

## Timing
- Reset values, applied immediately on `rst` rise:
  - `phase` = 0
  - `code` = 2^(W−1) (midscale; 512 for W=10)
  - `code_valid` = 0
  - `lfsr` = 16'hACE1
- Latency: `code` is valid after the posedge that samples `next_sample`=1. `code_valid` is high for the following cycle only.
- Back-to-back strobes on every cycle are supported, at one sample per cycle.
- `rst` asserted mid-stream returns to reset values asynchronously. The first strobe after release outputs the phase-0 sample.
- Minimum strobe spacing: none.

## Configuration
- `MULTI_WAVE_GEN_NOISE_EN` defined:
  - Includes a 16-bit Fibonacci LFSR with taps 16, 14, 13, 11.
  - The LFSR advances once per `next_sample`, in every mode.
  - `mode`=3 outputs noise.
- `MULTI_WAVE_GEN_NOISE_EN` undefined:
  - No LFSR hardware.
  - `mode`=3 outputs midscale, i.e. s = 0.

## Test plan
All scenarios use W=10 and P=24.
- Reset: assert `rst` mid-stream → `code`=512 and `code_valid`=0 immediately. After release, the first strobe with square mode and `vol`=0 gives 1023.
- Square: `fcw`=2^20, `vol`=0, 16 strobes at random spacing of 2–9 cycles → codes 1023×8, then 0×8, repeating. With `vol`=1 → 767×8, then 256×8.
- Sawtooth: `fcw`=2^20 → 0, 64, 128, …, 960, 0. `code_valid` pulses exactly once per strobe.
- Triangle: `fcw`=2^20 → 0, 128, …, 896, 1023, 895, …, 127, 0.
- Sync: `phase_sync` coincident with the 5th sawtooth strobe → that sample is 0 and the next is 64. `phase_sync` alone between strobes → the next sample is 0 and `code` holds until then.
- Noise, with the macro defined: `mode`=3 and `vol`=0 → the first code equals (16'hACE1[15:6] ^ 10'h200). The sequence matches the reference LFSR model for 1000 samples. Without the macro → constant 512.

Source files
------------

// File: rtl/multi_wave_gen.sv
// Phase-accumulator audio waveform generator (square, sawtooth, triangle, noise).
// Define MULTI_WAVE_GEN_NOISE_EN to build the 16-bit LFSR noise source for mode 3.
module multi_wave_gen #(
  parameter int CODE_WIDTH  = 10,
  parameter int PHASE_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   next_sample,
  input  logic [PHASE_WIDTH-1:0] fcw,
  input  logic [1:0]             mode,
  input  logic [2:0]             vol,
  input  logic                   phase_sync,
  output logic [CODE_WIDTH-1:0]  code,
  output logic                   code_valid
);

  localparam int W = CODE_WIDTH;
  localparam int P = PHASE_WIDTH;
  localparam logic [W-1:0] HALF    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  logic [P-1:0]        phase;
  logic [P-1:0]        phase_cur;
  logic [W-1:0]        top;
  logic [W-1:0]        tri_t;
  logic [W-1:0]        noise_val;
  logic signed [W-1:0] wave;
  logic signed [W-1:0] wave_att;
  logic [W-1:0]        code_next;

  // A coincident sync makes this strobe render phase 0 and then advance from 0.
  assign phase_cur = phase_sync ? '0 : phase;
  assign top       = phase_cur[P-1 -: W];
  assign tri_t     = phase_cur[P-1] ? ~phase_cur[P-2 -: W] : phase_cur[P-2 -: W];

`ifdef MULTI_WAVE_GEN_NOISE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11; advances on every strobe regardless of mode.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  generate
    if (W <= 16) begin : g_noise_narrow
      assign noise_val = lfsr[15 -: W];
    end else begin : g_noise_wide
      assign noise_val = {lfsr, {(W-16){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (next_sample) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`else
  assign noise_val = '0;
`endif

  always_comb begin
    wave = '0;
    case (mode)
      2'd0:    wave = phase_cur[P-1] ? HALF : MAX_POS;
      2'd1:    wave = top - HALF;
      2'd2:    wave = tri_t - HALF;
      default: wave = noise_val;
    endcase
  end

  // Shift kept in its own signed assignment so the offset add cannot make it logical.
  assign wave_att  = wave >>> vol;
  assign code_next = wave_att + HALF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      code       <= HALF;
      code_valid <= 1'b0;
    end else begin
      code_valid <= next_sample;
      if (next_sample) begin
        code  <= code_next;
        phase <= phase_cur + fcw;
      end else begin
        phase <= phase_cur;
      end
    end
  end

endmodule

// File: tb/tb_multi_wave_gen.sv
// Scoreboard bench for multi_wave_gen (W=10, P=24); expected codes are queued at
// each strobe and compared when code_valid is seen.
module tb_multi_wave_gen;

  localparam int W = 10;
  localparam int P = 24;
  localparam logic [P-1:0] F20 = 24'h100000;

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         next_sample;
  logic [P-1:0] fcw;
  logic [1:0]   mode;
  logic [2:0]   vol;
  logic         phase_sync;
  logic [W-1:0] code;
  logic         code_valid;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_strobe = 0;
  int   n_valid  = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [15:0] m_lfsr;

  multi_wave_gen #(.CODE_WIDTH(W), .PHASE_WIDTH(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .next_sample (next_sample),
    .fcw         (fcw),
    .mode        (mode),
    .vol         (vol),
    .phase_sync  (phase_sync),
    .code        (code),
    .code_valid  (code_valid)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [W-1:0] noise_code(input logic [15:0] l, input logic [2:0] v);
    logic signed [W-1:0] s;
    logic signed [W-1:0] sh;
    s  = l[15:6];
    sh = s >>> v;
    return sh + 10'd512;
  endfunction

  // Called at a negedge; returns at a negedge, gap cycles after the strobe cycle began.
  task automatic send(input logic [1:0] m, input logic [2:0] v, input logic [P-1:0] f,
                      input logic sync, input logic [W-1:0] expv, input string tag,
                      input int gap);
    mode = m; vol = v; fcw = f; phase_sync = sync; next_sample = 1'b1;
    exp_q.push_back('{tag, expv});
    n_strobe++;
    m_lfsr = lfsr_step(m_lfsr);
    @(negedge clk);
    next_sample = 1'b0; phase_sync = 1'b0;
    mode = 2'($urandom); vol = 3'($urandom); fcw = P'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic sync_alone();
    phase_sync = 1'b1;
    @(negedge clk);
    phase_sync = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_code", code, 512);
    check("rst_valid", code_valid, 0);
    exp_q.delete();
    m_lfsr = 16'hACE1;
    #10 rst = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && code_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.tag, code, mon_e.val);
      end
    end
  end

  initial begin
    rst = 1'b1; next_sample = 1'b0; phase_sync = 1'b0;
    fcw = '0; mode = '0; vol = '0;
    m_lfsr = 16'hACE1;
    #1;
    check("init_code", code, 512);
    check("init_valid", code_valid, 0);
    #20 rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 16; k++)
      send(2'd0, 3'd0, F20, 1'b0, (k < 8) ? 10'd1023 : 10'd0, "square_v0", $urandom_range(9, 2));
    for (int k = 0; k < 16; k++)
      send(2'd0, 3'd1, F20, 1'b0, (k < 8) ? 10'd767 : 10'd256, "square_v1", $urandom_range(9, 2));

    for (int k = 0; k < 18; k++)
      send(2'd1, 3'd0, F20, 1'b0, W'((k % 16) * 64), "saw", $urandom_range(9, 2));

    // Sync without a strobe clears phase but must leave code at the last sample.
    sync_alone();
    repeat (3) begin
      check("sync_hold", code, 64);
      @(negedge clk);
    end
    send(2'd1, 3'd0, F20, 1'b0, 10'd0, "saw_after_sync", 3);
    send(2'd1, 3'd0, F20, 1'b0, 10'd64, "saw_after_sync", 3);
    for (int k = 2; k < 6; k++)
      send(2'd1, 3'd0, F20, 1'b0, W'(k * 64), "saw_pre_sync", $urandom_range(9, 2));
    send(2'd1, 3'd0, F20, 1'b1, 10'd0, "saw_sync_strobe", 3);
    send(2'd1, 3'd0, F20, 1'b0, 10'd64, "saw_post_sync", 3);
    sync_alone();
    check("sync_hold2", code, 64);

    for (int k = 0; k < 17; k++)
      send(2'd2, 3'd0, F20, 1'b0,
           (k == 16) ? 10'd0 : (k < 8) ? W'(k * 128) : W'(1023 - (k - 8) * 128),
           "triangle", $urandom_range(9, 2));
    sync_alone();

    for (int k = 0; k < 4; k++) send(2'd1, 3'd0, '0, 1'b0, 10'd0, "dc_saw", 2);
    for (int k = 0; k < 3; k++) send(2'd0, 3'd0, '0, 1'b0, 10'd1023, "dc_square", 2);

    for (int k = 0; k < 16; k++)
      send(2'd1, 3'd0, F20, 1'b0, W'(k * 64), "saw_b2b", 1);
    @(negedge clk);

    send(2'd1, 3'd0, 24'h900000, 1'b0, 10'd0, "alias", 2);
    send(2'd1, 3'd0, 24'h900000, 1'b0, 10'd576, "alias", 2);
    send(2'd1, 3'd0, 24'h900000, 1'b0, 10'd128, "alias", 2);
    sync_alone();

    send(2'd1, 3'd3, F20, 1'b0, 10'd448, "saw_vol3", 2);
    send(2'd1, 3'd7, F20, 1'b0, 10'd508, "saw_vol7", 2);
    send(2'd0, 3'd2, F20, 1'b0, 10'd639, "square_vol2", 2);
    sync_alone();

    // Reset arriving while a fresh sample is being presented.
    mode = 2'd0; vol = 3'd0; fcw = F20; next_sample = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_code", code, 512);
    check("midrst_valid", code_valid, 0);
    exp_q.delete();
    m_lfsr = 16'hACE1;
    @(negedge clk);
    next_sample = 1'b0;
    #3 rst = 1'b0;
    @(negedge clk);
    send(2'd0, 3'd0, F20, 1'b0, 10'd1023, "first_after_rst", 3);

    reset_pulse();
`ifdef MULTI_WAVE_GEN_NOISE_EN
    send(2'd3, 3'd0, F20, 1'b0, 10'd179, "noise_first", 2);
    for (int i = 1; i < 1000; i++) begin
      logic [2:0] v;
      v = (i > 500) ? 3'(i % 8) : 3'd0;
      send(2'd3, v, F20, 1'b0, noise_code(m_lfsr, v), "noise_seq", $urandom_range(4, 1));
    end
`else
    for (int i = 0; i < 20; i++)
      send(2'd3, 3'($urandom), F20, 1'b0, 10'd512, "noise_off", $urandom_range(4, 1));
`endif

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("valid_per_strobe", n_valid, n_strobe);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
